// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch port
// and the data port. Data wins contention unless fetch has been passed over
// MAX_STREAK times in a row. Read responses are steered back to their owner
// by a tag pipeline that matches the memory read latency.
module mem_port_arbiter #(
    parameter int RD_LAT     = 1,   // memory read latency, 1..4
    parameter int MAX_STREAK = 4    // data grants allowed while fetch waits, 0 = no guard
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_we,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam bit         GUARD_EN   = (MAX_STREAK != 0);

    logic [3:0]        streak_q, streak_d;
    // Tag stage k: valid bit and owner (1 = data port, 0 = fetch port).
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;

    logic starve;
    logic data_win;
    logic fetch_win;

    // Byte offsets are dropped on the memory side; keep them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Per-cycle arbitration; both grants are held low while reset is asserted.
    always_comb begin
        starve    = GUARD_EN && (streak_q == STREAK_MAX);
        data_win  = d_req && !(i_req && starve) && !reset;
        fetch_win = i_req && !data_win && !reset;
    end

    assign d_gnt = data_win;
    assign i_gnt = fetch_win;
    assign m_en  = data_win | fetch_win;

    // Memory request mux: address of the winner, write fields only for data.
    always_comb begin
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_we    = 4'h0;
        if (data_win) begin
            m_addr  = {d_addr[31:2], 2'b00};
            m_wdata = d_wdata;
            m_we    = d_we;
        end else if (fetch_win) begin
            m_addr  = {i_addr[31:2], 2'b00};
        end
    end

    // Streak counts data grants that pushed a waiting fetch aside.
    always_comb begin
        streak_d = streak_q;
        if (!i_req || fetch_win) begin
            streak_d = 4'h0;
        end else if (data_win && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'h1;
        end
    end

    // Tag pipeline next state: stage 0 captures reads only, then shift.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_own_d    = tag_own_q;
        tag_vld_d[0] = fetch_win | (data_win && (d_we == 4'h0));
        tag_own_d[0] = data_win;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_own_d[k] = tag_own_q[k-1];
        end
    end

    // State registers; reset discards any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q  <= 4'h0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            streak_q  <= streak_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    assign i_rvalid = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign d_rvalid = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver predicts grants and read
// responses from the arbitration rules, a monitor pops and checks responses.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_we = '0;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, m_en;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_we;

    logic        s_i_gnt, s_d_gnt, s_i_rvalid, s_d_rvalid, s_m_en;
    logic [31:0] s_i_rdata, s_d_rdata, s_m_addr, s_m_wdata;
    logic [3:0]  s_m_we;
    logic [31:0] s_m_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RD_LAT(LAT), .MAX_STREAK(MAXS)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
    );

    // Strict-priority instance shares the stimulus; only its grants are checked.
    mem_port_arbiter #(.RD_LAT(LAT), .MAX_STREAK(0)) u_strict (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_gnt(s_d_gnt),
        .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .m_en(s_m_en), .m_addr(s_m_addr), .m_wdata(s_m_wdata), .m_we(s_m_we), .m_rdata(s_m_rdata)
    );

    typedef struct {
        logic        owner;   // 0 = fetch, 1 = data
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         exp_q[$];
    logic [31:0] env_mem[256];
    logic [31:0] shadow[256];
    logic [31:0] rd_pipe[LAT];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          streak_m = 0;

    function automatic logic [31:0] init_word(input int k);
        return {8'(k), 8'hA5, 8'(~k), 8'(k * 3)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural memory: reacts to the DUT's memory port with LAT-cycle reads.
    assign m_rdata = rd_pipe[LAT-1];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int k = 0; k < 256; k++) env_mem[k] <= init_word(k);
            for (int k = 0; k < LAT; k++) rd_pipe[k] <= 32'h0;
        end else begin
            if (m_en && m_we != 4'h0)
                env_mem[m_addr[9:2]] <= merge(env_mem[m_addr[9:2]], m_wdata, m_we);
            rd_pipe[0] <= env_mem[m_addr[9:2]];
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end

    // Monitor: every rvalid pulse must match the oldest predicted read.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_rvalid || d_rvalid) begin
                chk("rvalid_exclusive", 32'(i_rvalid & d_rvalid), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
                end else begin
                    rd_t e;
                    e = exp_q.pop_front();
                    chk("rvalid_owner", 32'(d_rvalid), 32'(e.owner));
                    chk("rdata", d_rvalid ? d_rdata : i_rdata, e.data);
                    chk("rvalid_latency", 32'(cyc), 32'(e.due));
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                rd_t m;
                m = exp_q.pop_front();
                chk("missed_rvalid", 32'(cyc), 32'(m.due));
            end
        end
    end

    // One arbitration cycle: drive, predict, compare, update the model.
    task automatic do_cycle(input logic ir, input logic [31:0] ia, input logic dr,
                            input logic [31:0] da, input logic [31:0] dw, input logic [3:0] dwe,
                            output logic gi, output logic gd, output logic act_gd);
        logic        exp_i, exp_d;
        logic [31:0] exp_addr;
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = dw; d_we = dwe;
        exp_d    = dr && !(ir && MAXS != 0 && streak_m == MAXS);
        exp_i    = ir && !exp_d;
        exp_addr = exp_d ? {da[31:2], 2'b00} : (exp_i ? {ia[31:2], 2'b00} : 32'h0);
        @(negedge clk);
        chk("i_gnt", 32'(i_gnt), 32'(exp_i));
        chk("d_gnt", 32'(d_gnt), 32'(exp_d));
        chk("m_en", 32'(m_en), 32'(exp_i || exp_d));
        chk("m_addr", m_addr, exp_addr);
        chk("m_we", 32'(m_we), exp_d ? 32'(dwe) : 32'h0);
        chk("m_wdata", m_wdata, exp_d ? dw : 32'h0);
        chk("strict_d_gnt", 32'(s_d_gnt), 32'(dr));
        chk("strict_i_gnt", 32'(s_i_gnt), 32'(ir && !dr));
        act_gd = d_gnt;
        if (exp_i) exp_q.push_back('{1'b0, shadow[ia[9:2]], cyc + LAT});
        if (exp_d) begin
            if (dwe == 4'h0) exp_q.push_back('{1'b1, shadow[da[9:2]], cyc + LAT});
            else shadow[da[9:2]] = merge(shadow[da[9:2]], dw, dwe);
        end
        if (!ir || exp_i) streak_m = 0;
        else if (exp_d && streak_m < MAXS) streak_m++;
        gi = exp_i;
        gd = exp_d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a, b, c;
        for (int k = 0; k < n; k++) do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, a, b, c);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_gnt"}, 32'(i_gnt), 32'h0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'h0);
        chk({tag, "_m_en"}, 32'(m_en), 32'h0);
        chk({tag, "_m_we"}, 32'(m_we), 32'h0);
        chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'h0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'h0);
    endtask

    initial begin
        logic        gi, gd, agd;
        logic        ip, dp;
        logic [31:0] ia, da, dw;
        logic [3:0]  dwe;
        logic [9:0]  pat;

        for (int k = 0; k < 256; k++) shadow[k] = init_word(k);

        // Outputs stay quiet under reset even with both ports requesting.
        i_req = 1'b1; d_req = 1'b1; d_we = 4'hF; i_addr = 32'h40; d_addr = 32'h80;
        @(negedge clk);
        chk_reset_outputs("rst0");
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
        reset = 1'b0;
        idle(1);

        // Reset one cycle after a fetch grant drops the in-flight read.
        do_cycle(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd, agd);
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 4'h0;
        exp_q.delete();
        streak_m = 0;
        @(negedge clk);
        chk_reset_outputs("rst1");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_read_i_rvalid", 32'(i_rvalid), 32'h0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        reset = 1'b0;
        idle(4);

        // Lone fetch with unaligned address.
        do_cycle(1'b1, 32'h0000_0106, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd, agd);
        idle(3);

        // Lone partial store, then read the word back.
        do_cycle(1'b0, 32'h0, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0011, gi, gd, agd);
        idle(3);
        do_cycle(1'b0, 32'h0, 1'b1, 32'h200, 32'h0, 4'h0, gi, gd, agd);
        idle(3);

        // Sustained contention: the guard lets fetch in after four data grants.
        pat = 10'b11110_11110;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 32'h44, 1'b1, 32'h88, 32'h0, 4'h0, gi, gd, agd);
            chk("contention_seq", 32'(agd), 32'(pat[9-k]));
        end
        idle(3);

        // Long contention then data drops: fetch granted in that same cycle.
        for (int k = 0; k < 8; k++)
            do_cycle(1'b1, 32'h48, 1'b1, 32'h8C, 32'h0, 4'h0, gi, gd, agd);
        do_cycle(1'b1, 32'h48, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd, agd);
        idle(3);

        // Interleaved reads return in grant order, back to back.
        do_cycle(1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 4'h0, gi, gd, agd);
        do_cycle(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0, gi, gd, agd);
        do_cycle(1'b0, 32'h0, 1'b1, 32'h30, 32'h0, 4'h0, gi, gd, agd);
        idle(3);

        // Random traffic: each port holds its request until granted.
        ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dw = '0; dwe = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                ia = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp  = 1'b1;
                da  = $urandom;
                dw  = $urandom;
                dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            do_cycle(ip, ia, dp, da, dw, dwe, gi, gd, agd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
        end
        idle(LAT + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
